// File: rtl/usb_device_protocol_fsm.sv
// USB device-side transaction engine for one endpoint: OUT/IN token handling, ACK/NAK handshakes,
// DATA0 retransmission on NAK, bad CRC or timeout, and abandonment after MAX_TRIES attempts. All outputs registered.
module usb_device_protocol_fsm #(
  parameter logic [6:0] DEV_ADDR  = 7'd5,
  parameter logic [3:0] DEV_ENDP  = 4'd4,
  parameter logic [3:0] MAX_TRIES = 4'd8,
  parameter logic [7:0] TIMEOUT   = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_valid,
  input  logic [3:0]  pid_in,
  input  logic [6:0]  addr_in,
  input  logic [3:0]  endp_in,
  input  logic        crc_ok,
  input  logic [63:0] data_in,
  input  logic        app_data_valid,
  input  logic [63:0] app_data,
  output logic        tx_valid,
  output logic [3:0]  pid_out,
  output logic [4:0]  crc_type,
  output logic [63:0] data_out,
  output logic [63:0] rx_data,
  output logic        rx_valid,
  output logic        app_data_taken,
  output logic        success,
  output logic        failure
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [4:0] CRC_HS    = 5'd5;
  localparam logic [4:0] CRC_DATA  = 5'd16;

  typedef enum logic [1:0] {S_IDLE, S_OUT_WAIT, S_IN_SEND, S_IN_WAIT} state_t;

  state_t      r_state, w_state;
  logic [7:0]  r_clk_count, w_clk_count;
  logic [3:0]  r_tries, w_tries;
  logic        w_tx_valid, w_rx_valid, w_app_data_taken, w_success, w_failure, w_retx;
  logic [3:0]  w_pid_out;
  logic [4:0]  w_crc_type;
  logic [63:0] w_data_out, w_rx_data;
  logic        w_match, w_token, w_timeout, w_exhausted;

  assign w_match     = pkt_valid & crc_ok & (addr_in == DEV_ADDR) & (endp_in == DEV_ENDP);
  assign w_token     = (pid_in == PID_OUT) | (pid_in == PID_IN);
  assign w_timeout   = (r_clk_count == TIMEOUT);
  assign w_exhausted = (r_tries == MAX_TRIES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_clk_count    <= '0;
      r_tries        <= '0;
      tx_valid       <= 1'b0;
      pid_out        <= '0;
      crc_type       <= '0;
      data_out       <= '0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      app_data_taken <= 1'b0;
      success        <= 1'b0;
      failure        <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_clk_count    <= w_clk_count;
      r_tries        <= w_tries;
      tx_valid       <= w_tx_valid;
      pid_out        <= w_pid_out;
      crc_type       <= w_crc_type;
      data_out       <= w_data_out;
      rx_data        <= w_rx_data;
      rx_valid       <= w_rx_valid;
      app_data_taken <= w_app_data_taken;
      success        <= w_success;
      failure        <= w_failure;
    end
  end

  always_comb begin
    w_state          = r_state;
    w_clk_count      = r_clk_count;
    w_tries          = r_tries;
    w_tx_valid       = 1'b0;
    w_pid_out        = pid_out;
    w_crc_type       = crc_type;
    w_data_out       = data_out;
    w_rx_data        = rx_data;
    w_rx_valid       = 1'b0;
    w_app_data_taken = 1'b0;
    w_success        = 1'b0;
    w_failure        = 1'b0;
    w_retx           = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clk_count = '0;
        w_tries     = '0;
        if (w_match && pid_in == PID_OUT)     w_state = S_OUT_WAIT;
        else if (w_match && pid_in == PID_IN) w_state = S_IN_SEND;
      end
      S_OUT_WAIT: begin
        if (w_exhausted) begin
          w_failure = 1'b1;
          w_state   = S_IDLE;
        end else if (pkt_valid) begin
          if (pid_in == PID_DATA0 && crc_ok) begin
            w_tx_valid = 1'b1;
            w_pid_out  = PID_ACK;
            w_crc_type = CRC_HS;
            w_rx_data  = data_in;
            w_rx_valid = 1'b1;
            w_success  = 1'b1;
            w_state    = S_IDLE;
          end else if (pid_in == PID_DATA0) begin
            w_tx_valid  = 1'b1;
            w_pid_out   = PID_NAK;
            w_crc_type  = CRC_HS;
            w_tries     = r_tries + 4'd1;
            w_clk_count = '0;
          end else if (w_token) begin
            w_clk_count = '0;
          end
        end else if (w_timeout) begin
          w_tries     = r_tries + 4'd1;
          w_clk_count = '0;
        end else begin
          w_clk_count = r_clk_count + 8'd1;
        end
      end
      S_IN_SEND: begin
        w_tx_valid = 1'b1;
        if (app_data_valid) begin
          w_pid_out   = PID_DATA0;
          w_crc_type  = CRC_DATA;
          w_data_out  = app_data;
          w_clk_count = '0;
          w_state     = S_IN_WAIT;
        end else begin
          w_pid_out  = PID_NAK;
          w_crc_type = CRC_HS;
          w_state    = S_IDLE;
        end
      end
      S_IN_WAIT: begin
        // Corrupted packets of any kind count as a failed delivery, ahead of PID decode
        if (w_exhausted) begin
          w_failure = 1'b1;
          w_state   = S_IDLE;
        end else if (pkt_valid) begin
          if (!crc_ok || pid_in == PID_NAK) begin
            w_retx = 1'b1;
          end else if (pid_in == PID_ACK) begin
            w_app_data_taken = 1'b1;
            w_success        = 1'b1;
            w_state          = S_IDLE;
          end else if (w_token) begin
            w_clk_count = '0;
          end
        end else if (w_timeout) begin
          w_retx = 1'b1;
        end else begin
          w_clk_count = r_clk_count + 8'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase
    if (w_retx) begin
      w_tx_valid  = 1'b1;
      w_pid_out   = PID_DATA0;
      w_crc_type  = CRC_DATA;
      w_tries     = r_tries + 4'd1;
      w_clk_count = '0;
    end
  end

endmodule

// File: doc/usb_device_protocol_fsm.md
USB_DEVICE_PROTOCOL_FSM -- requirements
Module: usb_device_protocol_fsm

Interface
REQ-001 SHALL have parameters: DEV_ADDR 7'd5 (device address); DEV_ENDP 4'd4 (endpoint); MAX_TRIES 4'd8 (retry/timeout limit); TIMEOUT 8'd255 (cycles per timeout).
REQ-002 SHALL have ports, clock and reset first:
  clk  in  1  sole clock, rising edge
  rst  in  1  asynchronous, active-high reset
  pkt_valid  in  1  1-cycle pulse: decoded host packet present on pid_in/addr_in/endp_in/data_in/crc_ok
  pid_in  in  4  packet PID (OUT 0001, IN 1001, DATA0 0011, ACK 0010, NAK 1010)
  addr_in  in  7  token address
  endp_in  in  4  token endpoint
  crc_ok  in  1  CRC check result for the packet
  data_in  in  64  DATA0 payload from host
  app_data_valid  in  1  application has IN data ready (level)
  app_data  in  64  IN payload from application
  tx_valid  out  1  1-cycle pulse: send packet described by pid_out/crc_type/data_out
  pid_out  out  4  PID to transmit
  crc_type  out  5  5 = token/handshake CRC, 16 = data CRC
  data_out  out  64  DATA0 payload to host
  rx_data  out  64  last good OUT payload
  rx_valid  out  1  1-cycle pulse: rx_data updated
  app_data_taken  out  1  1-cycle pulse: host ACKed IN payload
  success  out  1  1-cycle pulse: transaction completed
  failure  out  1  1-cycle pulse: transaction abandoned

Function
REQ-003 SHALL implement states IDLE, OUT_WAIT, IN_SEND, IN_WAIT; all outputs registered.
REQ-004 Token match SHALL be defined as pkt_valid & crc_ok & addr_in==DEV_ADDR & endp_in==DEV_ENDP.
REQ-005 IDLE: matching OUT token -> OUT_WAIT; matching IN token -> IN_SEND; clears clk_count (8b), tries (4b); any other packet ignored.
REQ-006 OUT_WAIT, pkt_valid with pid DATA0 and crc_ok: next cycle tx_valid=1, pid_out=ACK, crc_type=5, rx_data<=data_in, rx_valid=1, success=1, state IDLE.
REQ-007 OUT_WAIT, DATA0 with ~crc_ok: tx_valid=1, pid_out=NAK, crc_type=5, tries+1, clk_count<=0, stay.
REQ-008 IN_SEND, app_data_valid=1: tx_valid=1, pid_out=DATA0, crc_type=16, data_out<=app_data, clk_count<=0, state IN_WAIT; data_out held until next IN_SEND.
REQ-009 IN_SEND, app_data_valid=0: tx_valid=1, pid_out=NAK, crc_type=5, state IDLE, neither success nor failure.
REQ-010 IN_WAIT, pkt_valid pid ACK (crc_ok): app_data_taken=1, success=1, state IDLE.
REQ-011 IN_WAIT, pkt_valid pid NAK or any packet with ~crc_ok: retransmit DATA0 with held data_out (tx_valid=1, crc_type=16), tries+1, clk_count<=0.
REQ-012 OUT_WAIT/IN_WAIT with no pkt_valid: clk_count+1 per cycle; at clk_count==TIMEOUT, tries+1, clk_count<=0; IN_WAIT also retransmits DATA0 then.
REQ-013 In OUT_WAIT/IN_WAIT, tries==MAX_TRIES checked first each cycle: failure=1, state IDLE, no tx_valid.
REQ-014 pkt_valid in same cycle as clk_count==TIMEOUT: packet handled, timeout discarded.
REQ-015 In OUT_WAIT/IN_WAIT, token packets (OUT/IN) ignored except they reset clk_count.
REQ-016 tx_valid, rx_valid, app_data_taken, success, failure SHALL be high at most one cycle per event; success and failure never together.
REQ-017 tries and clk_count SHALL not wrap: tries max MAX_TRIES, clk_count 0..TIMEOUT.

Reset
REQ-018 rst=1 SHALL asynchronously force state IDLE and all outputs, clk_count, tries to 0, mid-transaction included; outputs stay 0 while rst held.
REQ-019 First token is accepted on the first rising clk edge after rst deasserts.

Verification
REQ-020 OUT token addr 5 endp 4, then DATA0 crc_ok data 64'hDEAD_BEEF -> one ACK tx pulse (crc_type 5), rx_data=64'hDEAD_BEEF, rx_valid and success pulse.
REQ-021 OUT token, then 8 DATA0 with crc_ok=0 -> 8 NAK pulses, then failure pulse, IDLE, no rx_valid.
REQ-022 IN token with app_data_valid=1 app_data=64'h1234 -> DATA0 tx (crc_type 16, data_out 64'h1234); host NAK -> identical retransmit; host ACK -> app_data_taken and success.
REQ-023 IN token, app_data_valid=0 -> single NAK tx, IDLE, no success/failure.
REQ-024 IN token, DATA0 sent, no host reply -> retransmit every 256 cycles; failure after 8th timeout.
REQ-025 Token with addr 3 or crc_ok=0 -> no tx; rst pulse during IN_WAIT -> all outputs 0, IDLE immediately.
